// File: rtl/sel_sort_ctrl.sv
// sel_sort_ctrl: sequencer for an in-place selection sort of a single-port RAM.
//   For each outer index i, it reads mem[i]. It then scans j = i+1..N_ELEM-1
//   and tracks the running minimum value. It drives update pulses into an
//   external minimum-address register. At the end of a pass it swaps mem[i]
//   with mem[min] when they differ.
//
// Ports:
//   i_clk, i_rst_n    clock (rising edge), asynchronous active-low reset
//   i_start           start request, sampled in IDLE only
//   o_busy            high in every state except IDLE
//   o_done            one-cycle pulse in DONE
//   o_mem_addr        RAM address (holds its last value when unused)
//   o_mem_we          RAM write enable
//   o_mem_wdata       RAM write data
//   i_mem_rdata       RAM read data, one cycle after the address
//   o_value_i/_j      current outer / inner index
//   o_update_i        load the min-address register with o_value_i
//   o_update_min      load the min-address register with o_value_j
//   i_addr_min        min-address register contents
module sel_sort_ctrl #(
    parameter int SIZE_ADDR = 8,
    parameter int SIZE_DATA = 8,
    parameter int N_ELEM    = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [SIZE_ADDR-1:0] o_mem_addr,
    output logic                 o_mem_we,
    output logic [SIZE_DATA-1:0] o_mem_wdata,
    input  logic [SIZE_DATA-1:0] i_mem_rdata,
    output logic [SIZE_ADDR-1:0] o_value_i,
    output logic [SIZE_ADDR-1:0] o_value_j,
    output logic                 o_update_i,
    output logic                 o_update_min,
    input  logic [SIZE_ADDR-1:0] i_addr_min
);

    typedef enum logic [3:0] {
        S_IDLE, S_RD_I, S_LD_I, S_RD_J, S_CMP, S_CHK, S_SW1, S_SW2, S_DONE
    } state_t;

    // End-of-range constants in index width, so the loops stop before any wrap
    // when N_ELEM == 2^SIZE_ADDR.
    localparam logic [SIZE_ADDR-1:0] LAST_J = SIZE_ADDR'(N_ELEM - 1);
    localparam logic [SIZE_ADDR-1:0] LAST_I = SIZE_ADDR'(N_ELEM - 2);

    state_t               state;
    logic [SIZE_ADDR-1:0] r_i, r_j;
    logic [SIZE_DATA-1:0] r_min_val, r_val_i;
    logic                 less;
    logic                 adv;

    assign less = i_mem_rdata < r_min_val;

    // The compared word only arrives during CMP. The update has to land in the
    // min-address register by CHK, so this pulse stays combinational.
    assign o_update_min = (state == S_CMP) && less;

    assign o_value_i = r_i;
    assign o_value_j = r_j;

    // End of pass: either no swap was needed, or the second swap write is done.
    assign adv = ((state == S_CHK) && (i_addr_min == r_i)) || (state == S_SW2);

    // Registered outputs are loaded for the state being entered.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= S_IDLE;
            r_i         <= '0;
            r_j         <= '0;
            r_min_val   <= '0;
            r_val_i     <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_we    <= 1'b0;
            o_mem_wdata <= '0;
            o_update_i  <= 1'b0;
        end else begin
            o_mem_we   <= 1'b0;
            o_update_i <= 1'b0;
            o_done     <= 1'b0;
            unique case (state)
                S_IDLE: if (i_start) begin
                    r_i        <= '0;
                    o_mem_addr <= '0;
                    o_update_i <= 1'b1;
                    o_busy     <= 1'b1;
                    state      <= S_RD_I;
                end
                S_RD_I: state <= S_LD_I;
                S_LD_I: begin
                    r_val_i    <= i_mem_rdata;
                    r_min_val  <= i_mem_rdata;
                    r_j        <= r_i + 1'b1;
                    o_mem_addr <= r_i + 1'b1;
                    state      <= S_RD_J;
                end
                S_RD_J: state <= S_CMP;
                S_CMP: begin
                    // Strict compare: on equal values, the first minimum is kept.
                    if (less) r_min_val <= i_mem_rdata;
                    if (r_j == LAST_J) begin
                        state <= S_CHK;
                    end else begin
                        r_j        <= r_j + 1'b1;
                        o_mem_addr <= r_j + 1'b1;
                        state      <= S_RD_J;
                    end
                end
                S_CHK: if (!adv) begin
                    o_mem_addr  <= i_addr_min;
                    o_mem_we    <= 1'b1;
                    o_mem_wdata <= r_val_i;
                    state       <= S_SW1;
                end
                S_SW1: begin
                    o_mem_addr  <= r_i;
                    o_mem_we    <= 1'b1;
                    o_mem_wdata <= r_min_val;
                    state       <= S_SW2;
                end
                S_SW2: ;
                S_DONE: begin
                    o_busy <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            if (adv) begin
                if (r_i == LAST_I) begin
                    o_done <= 1'b1;
                    state  <= S_DONE;
                end else begin
                    r_i        <= r_i + 1'b1;
                    o_mem_addr <= r_i + 1'b1;
                    o_update_i <= 1'b1;
                    state      <= S_RD_I;
                end
            end
        end
    end

endmodule

// File: tb/tb_sel_sort_ctrl.sv
module tb_sel_sort_ctrl;
    localparam int AW = 8;
    localparam int DW = 8;
    typedef logic [DW-1:0] arr4_t [4];

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start_a = 1'b0, start_b = 1'b0;
    always #5 clk = ~clk;

    int chk = 0, pass = 0;
    logic [15:0] exp_upd [$];

    // ---------------- instance A: N_ELEM = 4 ----------------
    logic          busy_a, done_a, we_a, upd_i_a, upd_min_a, load_a = 1'b0;
    logic [AW-1:0] addr_a, vi_a, vj_a, amin_a;
    logic [DW-1:0] wdata_a, rdata_a;
    logic [DW-1:0] mem_a [256];
    arr4_t         init_a;

    sel_sort_ctrl #(.SIZE_ADDR(AW), .SIZE_DATA(DW), .N_ELEM(4)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start_a), .o_busy(busy_a), .o_done(done_a),
        .o_mem_addr(addr_a), .o_mem_we(we_a), .o_mem_wdata(wdata_a), .i_mem_rdata(rdata_a),
        .o_value_i(vi_a), .o_value_j(vj_a), .o_update_i(upd_i_a), .o_update_min(upd_min_a),
        .i_addr_min(amin_a));

    always @(posedge clk) begin
        if (load_a) for (int k = 0; k < 4; k++) mem_a[k] <= init_a[k];
        else if (we_a) mem_a[addr_a] <= wdata_a;
        rdata_a <= mem_a[addr_a];
        if (upd_min_a) amin_a <= vj_a;
        else if (upd_i_a) amin_a <= vi_a;
    end

    // ---------------- instance B: N_ELEM = 2 ----------------
    logic          busy_b, done_b, we_b, upd_i_b, upd_min_b, load_b = 1'b0;
    logic [AW-1:0] addr_b, vi_b, vj_b, amin_b;
    logic [DW-1:0] wdata_b, rdata_b;
    logic [DW-1:0] mem_b [256];
    logic [DW-1:0] init_b [2];

    sel_sort_ctrl #(.SIZE_ADDR(AW), .SIZE_DATA(DW), .N_ELEM(2)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start_b), .o_busy(busy_b), .o_done(done_b),
        .o_mem_addr(addr_b), .o_mem_we(we_b), .o_mem_wdata(wdata_b), .i_mem_rdata(rdata_b),
        .o_value_i(vi_b), .o_value_j(vj_b), .o_update_i(upd_i_b), .o_update_min(upd_min_b),
        .i_addr_min(amin_b));

    always @(posedge clk) begin
        if (load_b) for (int k = 0; k < 2; k++) mem_b[k] <= init_b[k];
        else if (we_b) mem_b[addr_b] <= wdata_b;
        rdata_b <= mem_b[addr_b];
        if (upd_min_b) amin_b <= vj_b;
        else if (upd_i_b) amin_b <= vi_b;
    end

    // Reference: plain selection sort. Records where a new strict minimum is found,
    // the cycle in which DONE is expected (RD_I of pass 0 is cycle 1), and the
    // number of RAM writes.
    task automatic model4(input arr4_t d, output arr4_t s, output int cyc, output int nwe);
        arr4_t a;
        int m;
        logic [DW-1:0] t;
        a = d;
        exp_upd.delete();
        cyc = 1;
        nwe = 0;
        for (int i = 0; i < 3; i++) begin
            m = i;
            for (int j = i + 1; j < 4; j++)
                if (a[j] < a[m]) begin
                    m = j;
                    exp_upd.push_back({8'(i), 8'(j)});
                end
            cyc += 2 + 2 * (3 - i) + 1;
            if (m != i) begin
                t = a[i]; a[i] = a[m]; a[m] = t;
                cyc += 2;
                nwe += 2;
            end
        end
        s = a;
    endtask

    task automatic load_mem_a(input arr4_t d);
        init_a = d;
        @(negedge clk) load_a = 1'b1;
        @(negedge clk) load_a = 1'b0;
    endtask

    // Runs one sort on instance A and checks it against the model.
    task automatic run_a(input string nm, input arr4_t d, input bit hold);
        arr4_t s;
        int ecyc, ewe, dcyc, nwe, ndone;
        logic [15:0] got [$];
        bit ok;
        dcyc = 0; nwe = 0; ndone = 0;
        model4(d, s, ecyc, ewe);
        load_mem_a(d);
        start_a = 1'b1;
        for (int c = 1; c <= 400 && dcyc == 0; c++) begin
            @(negedge clk);
            if (c == 1) begin
                if (!hold) start_a = 1'b0;
                chk++;
                if (!(busy_a && upd_i_a && vi_a == 0))
                    $display("FAIL %s first_cycle: busy=%b upd_i=%b vi=%0d, want 1 1 0", nm, busy_a, upd_i_a, vi_a);
                else pass++;
            end
            if (upd_min_a) got.push_back({vi_a, vj_a});
            if (we_a) nwe++;
            if (done_a) begin ndone++; dcyc = c; end
        end
        chk++;
        if (dcyc != ecyc) $display("FAIL %s done_cycle: got %0d want %0d", nm, dcyc, ecyc);
        else pass++;
        chk++;
        if (nwe != ewe) $display("FAIL %s write_count: got %0d want %0d", nm, nwe, ewe);
        else pass++;
        ok = (got.size() == exp_upd.size());
        if (ok) foreach (got[k]) if (got[k] !== exp_upd[k]) ok = 1'b0;
        chk++;
        if (!ok) $display("FAIL %s update_min_log: got %0d pulses want %0d (or wrong i/j)", nm, got.size(), exp_upd.size());
        else pass++;
        @(negedge clk);
        chk++;
        if (done_a !== 1'b0 || busy_a !== 1'b0)
            $display("FAIL %s after_done: done=%b busy=%b want 0 0", nm, done_a, busy_a);
        else pass++;
        chk++;
        if ({mem_a[0], mem_a[1], mem_a[2], mem_a[3]} !== {s[0], s[1], s[2], s[3]})
            $display("FAIL %s ram: got %h %h %h %h want %h %h %h %h", nm,
                     mem_a[0], mem_a[1], mem_a[2], mem_a[3], s[0], s[1], s[2], s[3]);
        else pass++;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #3;
        chk++;
        if ({busy_a, done_a, addr_a, we_a, wdata_a, upd_i_a, upd_min_a, vi_a, vj_a} !== '0)
            $display("FAIL reset_outputs: busy=%b done=%b addr=%0d we=%b", busy_a, done_a, addr_a, we_a);
        else pass++;
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        run_a("unsorted", '{8'd3, 8'd1, 8'd2, 8'd0}, 1'b0);
        run_a("sorted", '{8'd0, 8'd1, 8'd2, 8'd3}, 1'b0);
        run_a("dups", '{8'd2, 8'd2, 8'd1, 8'd1}, 1'b0);
    endtask

    task automatic test_reset_mid_sort();
        arr4_t d;
        bit found;
        found = 1'b0;
        for (int k = 0; k < 4; k++) d[k] = DW'($urandom_range(0, 255));
        load_mem_a(d);
        start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            if (vi_a == 1 && vj_a == 2 && addr_a == 2) found = 1'b1; // RD_J, pass 1
            else @(negedge clk);
        end
        chk++;
        if (!found) $display("FAIL midreset_reach: pass 1 not reached, vi=%0d", vi_a);
        else pass++;
        @(negedge clk);   // CMP of pass 1
        #2 rst_n = 1'b0;
        #1;
        chk++;
        if ({busy_a, done_a, addr_a, we_a, wdata_a, upd_i_a, upd_min_a, vi_a, vj_a} !== '0)
            $display("FAIL midreset_outputs: busy=%b addr=%0d vi=%0d vj=%0d want all 0", busy_a, addr_a, vi_a, vj_a);
        else pass++;
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk++;
        if (busy_a !== 1'b0) $display("FAIL midreset_idle: busy=%b want 0", busy_a);
        else pass++;
        for (int k = 0; k < 4; k++) d[k] = mem_a[k];
        run_a("restart", d, 1'b0);
    endtask

    task automatic test_hold_start();
        bit seen;
        seen = 1'b0;
        run_a("hold", '{8'd9, 8'd4, 8'd7, 8'd1}, 1'b1);
        @(negedge clk);
        chk++;
        if (!(busy_a && upd_i_a && vi_a == 0))
            $display("FAIL hold_restart: busy=%b upd_i=%b vi=%0d want 1 1 0", busy_a, upd_i_a, vi_a);
        else pass++;
        start_a = 1'b0;
        for (int c = 0; c < 400 && !seen; c++) begin
            @(negedge clk);
            if (done_a) seen = 1'b1;
        end
        chk++;
        if (!seen) $display("FAIL hold_second_done: got 0 want 1");
        else pass++;
        @(negedge clk);
    endtask

    task automatic test_random();
        arr4_t d;
        for (int n = 0; n < 8; n++) begin
            for (int k = 0; k < 4; k++)
                d[k] = ($urandom_range(0, 1) != 0) ? DW'($urandom_range(0, 3)) : DW'($urandom_range(0, 255));
            run_a($sformatf("rand%0d", n), d, 1'b0);
        end
    endtask

    task automatic test_n2();
        int dcyc, nwe;
        dcyc = 0; nwe = 0;
        init_b[0] = 8'hFF;
        init_b[1] = 8'h00;
        @(negedge clk) load_b = 1'b1;
        @(negedge clk) begin load_b = 1'b0; start_b = 1'b1; end
        for (int c = 1; c <= 100 && dcyc == 0; c++) begin
            @(negedge clk);
            if (c == 1) start_b = 1'b0;
            if (we_b) nwe++;
            if (done_b) dcyc = c;
        end
        chk++;
        if (dcyc != 8) $display("FAIL n2_done_cycle: got %0d want 8", dcyc);
        else pass++;
        chk++;
        if (nwe != 2) $display("FAIL n2_write_count: got %0d want 2", nwe);
        else pass++;
        @(negedge clk);
        chk++;
        if (mem_b[0] !== 8'h00 || mem_b[1] !== 8'hFF)
            $display("FAIL n2_ram: got %h %h want 00 ff", mem_b[0], mem_b[1]);
        else pass++;
        chk++;
        if (busy_b !== 1'b0) $display("FAIL n2_idle: busy=%b want 0", busy_b);
        else pass++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_mid_sort();
        test_hold_start();
        test_random();
        test_n2();
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end
endmodule
